// File: rtl/pbl_pkg.sv
// pbl_pkg: shared loader state encoding and default instruction/address sizes
package pbl_pkg;
  localparam int PC_WIDTH = 8;
  localparam int INSTRUCTION_WIDTH = 16;
  localparam int BPW = INSTRUCTION_WIDTH / 8;
  typedef enum logic [2:0] {IDLE, COUNT, DATA, WRITE, CHECK, DONE, ERR} loader_state_t;
endpackage

// File: rtl/load_timer.sv
// load_timer: counts idle cycles and pulses expired when TIMEOUT_CYCLES pass without a clear
module load_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] count;
  assign expired = en && !clr && count == CW'(TIMEOUT_CYCLES - 1);
  // clear has priority; the owner leaves the counting states on expiry so no saturation is needed
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (clr) count <= '0;
    else if (en) count <= count + 1'b1;
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a counted, checksummed program into instruction memory while holding the core
module imem_loader import pbl_pkg::*; #(
  parameter int INSTRUCTION_WIDTH = pbl_pkg::INSTRUCTION_WIDTH,
  parameter int PC_WIDTH = pbl_pkg::PC_WIDTH,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load_start,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  output logic                         rx_ready,
  output logic                         mem_we,
  output logic [PC_WIDTH-1:0]          mem_waddr,
  output logic [INSTRUCTION_WIDTH-1:0] mem_wdata,
  output logic                         core_hold,
  output logic                         done,
  output logic                         err
);
  localparam int BPW = INSTRUCTION_WIDTH / 8;
  localparam int BW = BPW > 1 ? $clog2(BPW) : 1;
  loader_state_t state, nxt;
  logic acc, active, expired, last_byte, last_word;
  logic [BW-1:0] bcnt;
  logic [PC_WIDTH:0] idx, last_idx;
  logic [7:0] csum;
  logic [INSTRUCTION_WIDTH-1:0] word, shifted;
  assign acc = rx_valid && rx_ready;
  assign active = state inside {COUNT, DATA, CHECK};
  assign shifted = INSTRUCTION_WIDTH'({word, rx_data});
  assign last_byte = bcnt == BW'(BPW - 1);
  assign last_word = idx == last_idx;
  load_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .clr(acc || !active),
    .en(active),
    .expired(expired)
  );
  // next-state decode; expiry can only fire in a cycle with no accepted byte
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = load_start ? COUNT : IDLE;
      COUNT:   nxt = expired ? ERR : acc ? DATA : COUNT;
      DATA:    nxt = expired ? ERR : (acc && last_byte) ? WRITE : DATA;
      WRITE:   nxt = last_word ? CHECK : DATA;
      CHECK:   nxt = expired ? ERR : !acc ? CHECK : rx_data == csum ? DONE : ERR;
      DONE:    nxt = IDLE;
      ERR:     nxt = load_start ? COUNT : ERR;
      default: nxt = IDLE;
    endcase
  end
  // state register with outputs decoded from the next state so they are glitch-free registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      rx_ready <= 1'b0;
      mem_we <= 1'b0;
      core_hold <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= nxt;
      rx_ready <= nxt inside {COUNT, DATA, CHECK};
      mem_we <= nxt == WRITE;
      core_hold <= nxt != IDLE;
      done <= nxt == DONE;
      err <= nxt == ERR;
    end
  // byte assembly, checksum, word index and the registered write port
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      csum <= '0;
      word <= '0;
      bcnt <= '0;
      idx <= '0;
      last_idx <= '0;
      mem_waddr <= '0;
      mem_wdata <= '0;
    end else begin
      if (state == COUNT && acc) begin
        csum <= rx_data;
        last_idx <= rx_data == 8'd0 ? {1'b0, {PC_WIDTH{1'b1}}} : (PC_WIDTH+1)'(rx_data) - 1'b1;
        idx <= '0;
        bcnt <= '0;
      end
      if (state == DATA && acc) begin
        word <= shifted;
        csum <= csum ^ rx_data;
        bcnt <= last_byte ? '0 : bcnt + 1'b1;
        if (last_byte) begin
          mem_waddr <= idx[PC_WIDTH-1:0];
          mem_wdata <= shifted;
        end
      end
      if (state == WRITE && !last_word) idx <= idx + 1'b1;
    end
endmodule
